// File: rtl/ibex_efpga_responder.sv
// ---------------------------------------------------------------------------
// ibex_efpga_responder
//
// Bridges an Ibex custom-instruction request to an eFPGA fabric. The core
// holds req_valid_i until it samples ready_o high. Each accepted request is
// latched and launched to the fabric with a one-cycle fab_start_o strobe.
// The result is then collected in one of two ways:
//   - fixed mode (delay != 0): after exactly delay WAIT cycles
//   - handshake mode (delay == 0): on fab_done_i, or aborted with an error
//     after TIMEOUT_CYCLES WAIT cycles
// An illegal optype (2'b11) skips the fabric and completes with an error.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_i                level request from the core
//   optype_i                   00 -> result A, 01 -> B, 10 -> C, 11 illegal
//   operand_a_i, operand_b_i   source operands
//   delay_i                    fabric latency in cycles, 0 = handshake mode
//   ready_o                    completion (or idle) to the core's EX stage
//   result_o                   selected fabric result, held until next capture
//   err_o                      illegal optype / timeout, valid in DONE only
//   fab_op_o, fab_operand_*_o  registered copy of the accepted request
//   fab_start_o                one-cycle launch strobe
//   fab_done_i                 fabric completion strobe (handshake mode)
//   fab_result_[abc]_i         fabric result buses
//   busy_o                     high in LAUNCH, WAIT and DONE
// ---------------------------------------------------------------------------
module ibex_efpga_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [1:0]  optype_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [3:0]  delay_i,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic        err_o,
  output logic [1:0]  fab_op_o,
  output logic [31:0] fab_operand_a_o,
  output logic [31:0] fab_operand_b_o,
  output logic        fab_start_o,
  input  logic        fab_done_i,
  input  logic [31:0] fab_result_a_i,
  input  logic [31:0] fab_result_b_i,
  input  logic [31:0] fab_result_c_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Counter value on the final handshake WAIT cycle before timing out.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  delay_q, delay_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [31:0] sel_result;

  always_comb begin
    case (op_q)
      2'b00:   sel_result = fab_result_a_i;
      2'b01:   sel_result = fab_result_b_i;
      2'b10:   sel_result = fab_result_c_i;
      default: sel_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      delay_q  <= 4'd0;
      op_q     <= 2'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = optype_i;
          opa_d   = operand_a_i;
          opb_d   = operand_b_i;
          delay_d = delay_i;
          if (optype_i == 2'b11) begin
            // Illegal op never reaches the fabric.
            result_d = 32'd0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        if (!req_valid_i) begin
          state_d = S_IDLE;
        end else begin
          // Fixed mode counts down from delay; handshake counts up to timeout.
          cnt_d   = (delay_q != 4'd0) ? {4'd0, delay_q} : 8'd0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!req_valid_i) begin
          // Flush: abandon without touching result_o.
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (delay_q != 4'd0) begin
          if (cnt_q <= 8'd1) begin
            result_d = sel_result;
            err_d    = 1'b0;
            cnt_d    = 8'd0;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          // fab_done_i wins over a timeout in the same cycle.
          if (fab_done_i) begin
            result_d = sel_result;
            err_d    = 1'b0;
            cnt_d    = 8'd0;
            state_d  = S_DONE;
          end else if (cnt_q >= TO_LAST) begin
            result_d = 32'd0;
            err_d    = 1'b1;
            cnt_d    = 8'd0;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        err_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_o         = ((state_q == S_IDLE) && !req_valid_i) || (state_q == S_DONE);
  assign busy_o          = (state_q != S_IDLE);
  assign fab_start_o     = (state_q == S_LAUNCH);
  assign result_o        = result_q;
  assign err_o           = err_q;
  assign fab_op_o        = op_q;
  assign fab_operand_a_o = opa_q;
  assign fab_operand_b_o = opb_q;

endmodule

// File: tb/tb_ibex_efpga_responder.sv
module tb_ibex_efpga_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_valid4;
  logic [1:0]  optype;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  delay;
  logic        fab_done;
  logic [31:0] res_a;
  logic [31:0] res_b;
  logic [31:0] res_c;

  logic        ready, err, fab_start, busy;
  logic [31:0] result, fopa, fopb;
  logic [1:0]  fop;

  logic        ready4, err4, fab_start4, busy4;
  logic [31:0] result4, fopa4, fopb4;
  logic [1:0]  fop4;

  int errors = 0;
  int checks = 0;

  ibex_efpga_responder u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .optype_i(optype),
    .operand_a_i(operand_a), .operand_b_i(operand_b), .delay_i(delay),
    .ready_o(ready), .result_o(result), .err_o(err), .fab_op_o(fop),
    .fab_operand_a_o(fopa), .fab_operand_b_o(fopb), .fab_start_o(fab_start),
    .fab_done_i(fab_done), .fab_result_a_i(res_a), .fab_result_b_i(res_b),
    .fab_result_c_i(res_c), .busy_o(busy)
  );

  ibex_efpga_responder #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid4), .optype_i(optype),
    .operand_a_i(operand_a), .operand_b_i(operand_b), .delay_i(delay),
    .ready_o(ready4), .result_o(result4), .err_o(err4), .fab_op_o(fop4),
    .fab_operand_a_o(fopa4), .fab_operand_b_o(fopb4), .fab_start_o(fab_start4),
    .fab_done_i(fab_done), .fab_result_a_i(res_a), .fab_result_b_i(res_b),
    .fab_result_c_i(res_c), .busy_o(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
    checks++; if (busy !== 1'b0 || fab_start !== 1'b0) begin errors++; $display("FAIL reset_busy_start: got %b%b required 00", busy, fab_start); end
    checks++; if (result !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_result_err: got %h/%b required 0/0", result, err); end
    checks++; if (fop !== 2'd0 || fopa !== 32'd0 || fopb !== 32'd0) begin errors++; $display("FAIL reset_fab_regs: got %h %h %h required 0", fop, fopa, fopb); end
    checks++; if (result4 !== 32'd0 || busy4 !== 1'b0 || err4 !== 1'b0) begin errors++; $display("FAIL reset_dut4: got %h %b %b required 0 0 0", result4, busy4, err4); end
    rst_n = 1'b1;
    step();
  endtask

  // delay 3, optype B: start at cycle 1, ready at cycle 5
  task automatic test_fixed();
    req_valid = 1'b1; optype = 2'b01; delay = 4'd3;
    operand_a = 32'h0000_1111; operand_b = 32'h0000_2222;
    res_a = 32'hAAAA_0000; res_b = 32'hDEAD_BEEF; res_c = 32'hCCCC_0000;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fixed_c0_ready: got %b required 0", ready); end
    step(); // cycle 1 LAUNCH
    checks++; if (fab_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fixed_c1_start: got start=%b busy=%b required 1 1", fab_start, busy); end
    checks++; if (fop !== 2'b01 || fopa !== 32'h0000_1111 || fopb !== 32'h0000_2222) begin errors++; $display("FAIL fixed_fab_regs: got %h %h %h required 1 00001111 00002222", fop, fopa, fopb); end
    step(); // cycle 2 WAIT; inputs changed and stray done must be ignored
    optype = 2'b00; operand_a = 32'h9999_9999; delay = 4'd9; fab_done = 1'b1;
    checks++; if (fab_start !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL fixed_c2: got start=%b ready=%b required 0 0", fab_start, ready); end
    step(); // cycle 3
    fab_done = 1'b0;
    checks++; if (ready !== 1'b0 || fop !== 2'b01 || fopa !== 32'h0000_1111) begin errors++; $display("FAIL fixed_c3_hold: got ready=%b op=%h a=%h required 0 1 00001111", ready, fop, fopa); end
    step(); // cycle 4
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fixed_c4_ready: got %b required 0", ready); end
    step(); // cycle 5 DONE
    checks++; if (ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fixed_c5_done: got ready=%b busy=%b required 1 1", ready, busy); end
    checks++; if (result !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL fixed_result: got %h err=%b required deadbeef 0", result, err); end
    req_valid = 1'b0;
    step(); // cycle 6 IDLE
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fixed_idle_hold: got busy=%b ready=%b res=%h required 0 1 deadbeef", busy, ready, result); end
  endtask

  // delay 5 flushed on 2nd WAIT cycle, then two back-to-back requests
  task automatic test_flush_back_to_back();
    req_valid = 1'b1; optype = 2'b00; delay = 4'd5; res_a = 32'h5555_5555;
    #1;
    step(); // c1 LAUNCH
    step(); // c2 WAIT1
    step(); // c3 WAIT2
    req_valid = 1'b0;
    step(); // c4 IDLE
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got busy=%b ready=%b required 0 1", busy, ready); end
    checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_result_hold: got %h required deadbeef", result); end
    req_valid = 1'b1; optype = 2'b00; delay = 4'd1; res_a = 32'h1111_1111;
    step(); // c5 LAUNCH
    checks++; if (fab_start !== 1'b1) begin errors++; $display("FAIL b2b_first_start: got %b required 1", fab_start); end
    step(); // c6 WAIT
    step(); // c7 DONE
    checks++; if (ready !== 1'b1 || result !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_done: got ready=%b res=%h required 1 11111111", ready, result); end
    step(); // c8 IDLE with new request presented
    optype = 2'b01; delay = 4'd2; res_b = 32'hB2B2_B2B2; operand_b = 32'h0000_0B0B;
    #1;
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b busy=%b required 0 0", ready, busy); end
    step(); // c9 LAUNCH
    checks++; if (fab_start !== 1'b1 || fop !== 2'b01 || fopb !== 32'h0000_0B0B) begin errors++; $display("FAIL b2b_second_start: got start=%b op=%h b=%h required 1 1 00000b0b", fab_start, fop, fopb); end
    step(); // c10
    step(); // c11
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_early: got ready=%b required 0", ready); end
    step(); // c12 DONE
    checks++; if (ready !== 1'b1 || result !== 32'hB2B2_B2B2 || err !== 1'b0) begin errors++; $display("FAIL b2b_second_done: got ready=%b res=%h err=%b required 1 b2b2b2b2 0", ready, result, err); end
    req_valid = 1'b0;
    step();
  endtask

  // handshake, done on 7th WAIT cycle, stray done during LAUNCH
  task automatic test_handshake();
    req_valid = 1'b1; optype = 2'b10; delay = 4'd0; res_c = 32'h1234_5678;
    #1;
    step(); // c1 LAUNCH
    fab_done = 1'b1;
    step(); // c2 WAIT1
    fab_done = 1'b0;
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL hs_launch_done_ignored: got busy=%b ready=%b required 1 0", busy, ready); end
    for (int i = 3; i <= 8; i++) step(); // c8 = WAIT7
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_wait7: got ready=%b required 0", ready); end
    fab_done = 1'b1;
    step(); // c9 DONE
    fab_done = 1'b0;
    checks++; if (ready !== 1'b1 || result !== 32'h1234_5678 || err !== 1'b0) begin errors++; $display("FAIL hs_done: got ready=%b res=%h err=%b required 1 12345678 0", ready, result, err); end
    req_valid = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL hs_idle: got busy=%b err=%b required 0 0", busy, err); end
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; optype = 2'b11; delay = 4'd4;
    #1;
    step(); // c1 DONE
    checks++; if (ready !== 1'b1 || fab_start !== 1'b0) begin errors++; $display("FAIL illegal_done: got ready=%b start=%b required 1 0", ready, fab_start); end
    checks++; if (err !== 1'b1 || result !== 32'd0) begin errors++; $display("FAIL illegal_err: got err=%b res=%h required 1 0", err, result); end
    req_valid = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || fab_start !== 1'b0) begin errors++; $display("FAIL illegal_idle: got busy=%b start=%b required 0 0", busy, fab_start); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; optype = 2'b01; delay = 4'd5;
    operand_a = 32'hCAFE_0001; operand_b = 32'hCAFE_0002; res_b = 32'h7777_7777;
    #1;
    step(); // c1 LAUNCH
    step(); // c2 WAIT
    rst_n = 1'b0;
    step(); // c3 after reset edge
    checks++; if (busy !== 1'b0 || fab_start !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b start=%b ready=%b required 0 0 0", busy, fab_start, ready); end
    checks++; if (fop !== 2'd0 || fopa !== 32'd0 || fopb !== 32'd0 || result !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_data: got %h %h %h %h %b required all 0", fop, fopa, fopb, result, err); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || result !== 32'd0) begin errors++; $display("FAIL rstmid_after: got busy=%b ready=%b res=%h required 0 1 0", busy, ready, result); end
  endtask

  // TIMEOUT_CYCLES=4 instance: done coinciding with timeout, then a real timeout
  task automatic test_timeout();
    req_valid4 = 1'b1; optype = 2'b00; delay = 4'd0; res_a = 32'hA5A5_A5A5;
    #1;
    for (int i = 1; i <= 5; i++) step(); // c5 = WAIT4
    fab_done = 1'b1;
    step(); // c6 DONE
    fab_done = 1'b0;
    checks++; if (ready4 !== 1'b1 || err4 !== 1'b0 || result4 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL to_tie: got ready=%b err=%b res=%h required 1 0 a5a5a5a5", ready4, err4, result4); end
    req_valid4 = 1'b0;
    step();
    req_valid4 = 1'b1;
    #1;
    step(); // c1 LAUNCH
    checks++; if (fab_start4 !== 1'b1) begin errors++; $display("FAIL to_start: got %b required 1", fab_start4); end
    for (int i = 2; i <= 5; i++) step(); // c5 = WAIT4
    checks++; if (ready4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL to_wait4: got ready=%b busy=%b required 0 1", ready4, busy4); end
    step(); // c6 DONE
    checks++; if (ready4 !== 1'b1 || err4 !== 1'b1 || result4 !== 32'd0) begin errors++; $display("FAIL to_abort: got ready=%b err=%b res=%h required 1 1 0", ready4, err4, result4); end
    req_valid4 = 1'b0;
    step();
    checks++; if (busy4 !== 1'b0 || err4 !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b err=%b required 0 0", busy4, err4); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0;
    optype = 2'b00; operand_a = 32'd0; operand_b = 32'd0; delay = 4'd0;
    fab_done = 1'b0; res_a = 32'd0; res_b = 32'd0; res_c = 32'd0;
    test_reset();
    test_fixed();
    test_flush_back_to_back();
    test_handshake();
    test_illegal();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_efpga_responder.md
IBEX_EFPGA_RESPONDER -- requirements
Module: ibex_efpga_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT cycles in handshake mode (delay 0) before abort-with-error; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 req_valid_i  input  1  SHALL be the core-side level request, held high until ready_o is sampled high.
REQ-005 optype_i  input  2  SHALL be the custom-instruction type: 00 selects result A, 01 B, 10 C, 11 illegal.
REQ-006 operand_a_i / operand_b_i  input  32 each  SHALL be the source operands.
REQ-007 delay_i  input  4  SHALL be the fabric latency in cycles; 0 selects handshake mode.
REQ-008 ready_o  output  1  SHALL indicate completion (or idle), driving the core's EX-stage ready.
REQ-009 result_o  output  32  SHALL be the selected fabric result.
REQ-010 err_o  output  1  SHALL flag an illegal optype or timeout; valid only while ready_o=1 in DONE.
REQ-011 fab_op_o  output  2; fab_operand_a_o / fab_operand_b_o  output  32 each  SHALL be registered copies of the accepted request.
REQ-012 fab_start_o  output  1  SHALL be a one-cycle launch strobe to the fabric.
REQ-013 fab_done_i  input  1  SHALL be the fabric completion strobe, used in handshake mode only.
REQ-014 fab_result_a_i / fab_result_b_i / fab_result_c_i  input  32 each  SHALL be the fabric result buses.
REQ-015 busy_o  output  1  SHALL be high in LAUNCH, WAIT and DONE.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, DONE.
REQ-017 IDLE: ready_o = !req_valid_i; on req_valid_i=1, latch operands, optype and delay_i, and go to LAUNCH, or go to DONE with err set if optype_i=11.
REQ-018 LAUNCH: fab_start_o=1 for exactly this cycle; load the counter (delay_q, or 0 in handshake mode); go to WAIT.
REQ-019 WAIT, fixed mode (delay_q>0): stay exactly delay_q cycles; on the last cycle capture the selected fab_result into result_o; go to DONE.
REQ-020 WAIT, handshake mode: on fab_done_i=1 capture the selected result and go to DONE; after TIMEOUT_CYCLES cycles without done, set result_o=0 and err=1, then go to DONE.
REQ-021 DONE: ready_o=1 for exactly one cycle; err_o valid; go to IDLE unconditionally.
REQ-022 Latency SHALL be accept(cycle 0) -> DONE at cycle 2+delay_q in fixed mode; illegal optype reaches DONE at cycle 1.
REQ-023 A back-to-back request (req_valid_i high in the IDLE cycle after DONE) SHALL be accepted in that IDLE cycle.
REQ-024 If req_valid_i drops in LAUNCH or WAIT (flush), the FSM SHALL return to IDLE next cycle, leave result_o unchanged, and not assert DONE.
REQ-025 fab_done_i SHALL be ignored outside WAIT and in fixed mode; fab_done_i and timeout in the same cycle SHALL resolve as done (no error).
REQ-026 result_o SHALL hold its last captured value until the next capture.
REQ-027 Inputs SHALL be sampled only on acceptance; changes during LAUNCH/WAIT SHALL have no effect.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, counter=0, result_o=0, err_o=0, fab_start_o=0, busy_o=0, fab_op_o=0, fab operands=0.
REQ-029 Reset SHALL override any in-flight operation without a fab_start_o or ready_o pulse.

Verification
REQ-030 Fixed mode: optype=01, delay_i=3, fab_result_b_i=0xDEADBEEF -> fab_start_o at cycle 1, ready_o=1 at cycle 5, result_o=0xDEADBEEF, err_o=0.
REQ-031 Handshake mode: delay_i=0, optype=10, fab_done_i at the 7th WAIT cycle with C=0x12345678 -> DONE the next cycle, result_o=0x12345678.
REQ-032 Timeout: delay_i=0, no fab_done_i, TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, result_o=0, err_o=1.
REQ-033 Illegal optype=11 -> no fab_start_o, ready_o=1 at cycle 1, err_o=1, result_o=0.
REQ-034 Flush: req_valid_i deasserted on the 2nd WAIT cycle, delay_i=5 -> IDLE next cycle, no DONE, result_o unchanged; a back-to-back request after DONE is accepted immediately.
REQ-035 Reset mid-WAIT -> all outputs at reset values next cycle, no ready_o pulse.
